// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bundle for the GPR file: read ports, writeback, issue
// tracking and debug read.
interface regfile_sb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR_READ    = 2
) ();
    logic [NR_READ*ADDR_WIDTH-1:0] raddr;
    logic [NR_READ*DATA_WIDTH-1:0] rdata;
    logic [NR_READ-1:0]            rbusy;
    logic                          wen;
    logic [ADDR_WIDTH-1:0]         waddr;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          iss_valid;
    logic [ADDR_WIDTH-1:0]         iss_rd;
    logic [ADDR_WIDTH:0]           pend_cnt;
    logic [ADDR_WIDTH-1:0]         dbg_addr;
    logic [DATA_WIDTH-1:0]         dbg_data;

    modport master (
        output raddr, wen, waddr, wdata, iss_valid, iss_rd, dbg_addr,
        input  rdata, rbusy, pend_cnt, dbg_data
    );

    modport slave (
        input  raddr, wen, waddr, wdata, iss_valid, iss_rd, dbg_addr,
        output rdata, rbusy, pend_cnt, dbg_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port GPR file with write bypass, optional hardwired zero register
// and a per-register pending-producer scoreboard for RAW stalls in decode.
module regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic                  wr_en, set_en, inc, dec;
    logic [ADDR_WIDTH-1:0] rd_addr [NR_READ];

    assign wr_en  = bus.wen && !(ZR && (bus.waddr == '0));
    assign set_en = bus.iss_valid && !(ZR && (bus.iss_rd == '0));

    // Issue is applied after writeback so a new producer supersedes the old one.
    always_comb begin
        busy_d = busy_q;
        if (bus.wen) busy_d[bus.waddr] = 1'b0;
        if (set_en)  busy_d[bus.iss_rd] = 1'b1;
    end

    always_comb begin
        inc    = set_en && !busy_q[bus.iss_rd];
        dec    = bus.wen && busy_q[bus.waddr] && !(set_en && (bus.iss_rd == bus.waddr));
        pend_d = pend_q;
        if (inc && !dec)      pend_d = pend_q + CW'(1);
        else if (dec && !inc) pend_d = pend_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            if (wr_en) rf_q[bus.waddr] <= bus.wdata;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NR_READ; g++) begin : g_raddr
        assign rd_addr[g] = bus.raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int i = 0; i < NR_READ; i++) begin
            if (ZR && (rd_addr[i] == '0)) begin
                bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                bus.rbusy[i]                          = 1'b0;
            end else if (BP && bus.wen && (bus.waddr == rd_addr[i])) begin
                bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
                bus.rbusy[i]                          = 1'b0;
            end else begin
                bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[rd_addr[i]];
                bus.rbusy[i]                          = busy_q[rd_addr[i]];
            end
        end
    end

    assign bus.pend_cnt = pend_q;
    assign bus.dbg_data = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb against a behavioural model of the
// register contents and the set of registers with pending producers.
module tb_regfile_sb;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;

    logic [DW-1:0] m_rf [DEPTH];
    bit            m_busy [DEPTH];

    regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) bus ();

    regfile_sb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int busy_count();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) n += m_busy[r] ? 1 : 0;
        return n;
    endfunction

    task automatic idle();
        rst           = 1'b0;
        bus.raddr     = '0;
        bus.wen       = 1'b0;
        bus.waddr     = '0;
        bus.wdata     = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.dbg_addr  = '0;
    endtask

    task automatic set_raddr(input int p, input int a);
        bus.raddr[p*AW +: AW] = AW'(a);
    endtask

    // Compare all outputs against the model, then let one clock edge commit.
    task automatic step(input bit do_check);
        int a;
        logic [DW-1:0] ed;
        logic eb;
        #2;
        if (do_check) begin
            for (int p = 0; p < NR; p++) begin
                a = int'(bus.raddr[p*AW +: AW]);
                if (a == 0) begin
                    ed = '0; eb = 1'b0;
                end else if (bus.wen && int'(bus.waddr) == a) begin
                    ed = bus.wdata; eb = 1'b0;
                end else begin
                    ed = m_rf[a]; eb = m_busy[a];
                end
                check($sformatf("rdata%0d@%0d", p, a), bus.rdata[p*DW +: DW], ed);
                check($sformatf("rbusy%0d@%0d", p, a), DW'(bus.rbusy[p]), DW'(eb));
            end
            check("pend_cnt", DW'(bus.pend_cnt), DW'(busy_count()));
            check($sformatf("dbg_data@%0d", bus.dbg_addr), bus.dbg_data, m_rf[bus.dbg_addr]);
        end
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_rf[r] = '0; m_busy[r] = 1'b0;
            end
        end else begin
            if (bus.wen && bus.waddr != 0) m_rf[bus.waddr] = bus.wdata;
            if (bus.wen) m_busy[bus.waddr] = 1'b0;
            if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        // Reset with a write that must be dropped.
        rst = 1'b1; bus.wen = 1'b1; bus.waddr = 5'd3; bus.wdata = 64'd5;
        step(0); step(0);
        idle(); set_raddr(0, 3); set_raddr(1, 3); bus.dbg_addr = 5'd3;
        step(1);

        // Same-cycle bypass, then the array value.
        bus.wen = 1'b1; bus.waddr = 5'd5; bus.wdata = 64'hDEAD; set_raddr(0, 5);
        step(1);
        idle(); set_raddr(0, 5); bus.dbg_addr = 5'd5;
        step(1);

        // Zero register ignores writes and issues.
        bus.wen = 1'b1; bus.waddr = 5'd0; bus.wdata = 64'd7;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
        step(1);
        idle();
        step(1);

        // Two producers, then one writeback.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4; step(1);
        bus.iss_rd = 5'd9; step(1);
        idle(); set_raddr(0, 4); set_raddr(1, 9); step(1);
        bus.wen = 1'b1; bus.waddr = 5'd4; bus.wdata = 64'h44; step(1);
        idle(); set_raddr(0, 4); set_raddr(1, 9); step(1);

        // Issue and writeback to the same busy register in one cycle.
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd6; step(1);
        bus.wen = 1'b1; bus.waddr = 5'd6; bus.wdata = 64'h6666;
        set_raddr(1, 6); step(1);
        idle(); set_raddr(0, 6); bus.dbg_addr = 5'd6; step(1);

        // Writeback to a non-busy register must not underflow.
        bus.wen = 1'b1; bus.waddr = 5'd12; bus.wdata = 64'h12; step(1);
        idle(); set_raddr(0, 12); step(1);

        // Fill every register busy, then reset mid-stream.
        for (int r = 1; r < DEPTH; r++) begin
            idle(); bus.iss_valid = 1'b1; bus.iss_rd = AW'(r); set_raddr(0, r - 1);
            step(1);
        end
        idle(); step(1);
        rst = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; step(1);
        for (int r = 0; r < DEPTH; r++) begin
            idle(); bus.dbg_addr = AW'(r); set_raddr(0, r); set_raddr(1, DEPTH - 1 - r);
            step(1);
        end

        // Random traffic with biased address collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst           = ($urandom_range(0, 99) == 0);
            bus.wen       = $urandom_range(0, 1) == 1;
            bus.waddr     = AW'($urandom_range(0, 15));
            bus.wdata     = {$urandom, $urandom};
            bus.iss_valid = $urandom_range(0, 2) != 0;
            bus.iss_rd    = ($urandom_range(0, 3) == 0) ? bus.waddr : AW'($urandom_range(0, 15));
            bus.dbg_addr  = AW'($urandom_range(0, DEPTH - 1));
            for (int p = 0; p < NR; p++)
                set_raddr(p, ($urandom_range(0, 2) == 0) ? int'(bus.waddr) : $urandom_range(0, 15));
            step(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
